// File: rtl/fp_defs_pkg.sv
// Shared float-format constants for the 16-bit float (sign, 7-bit exp bias 63, 8-bit fraction).
package fp_defs;

    localparam int unsigned FP_W        = 16;
    localparam int unsigned FP_SIGN_POS = 15;
    localparam int unsigned FP_EXP_W    = 7;
    localparam int unsigned FP_MANT_W   = 8;
    localparam int unsigned FP_EXP_BIAS = 63;
    localparam int unsigned FP_POS_W    = 4;
    localparam logic [FP_W-1:0] FP_ZERO = 16'h0000;

endpackage

// File: rtl/fp_lod16.sv
// Combinational 16-bit leading-one detector: position of the highest set bit plus zero flag.
module fp_lod16
    import fp_defs::*;
(
    input  logic [FP_W-1:0]     vec,
    output logic [FP_POS_W-1:0] pos,
    output logic                zero
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        pos  = '0;
        zero = 1'b1;
        for (int i = 0; i < int'(FP_W); i++) begin
            if (vec[i]) begin
                pos  = FP_POS_W'(i);
                zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fp_int2fp.sv
// Three-stage fixed-point to 16-bit float converter with valid/ready back-pressure.
module fp_int2fp
    import fp_defs::*;
#(
    parameter int unsigned FRAC_BITS = 0
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [FP_W-1:0] int_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [FP_W-1:0] res_o
);

    localparam int unsigned DROP_W = FP_W - 1 - FP_MANT_W;

    logic                advance;

    logic                s1_valid;
    logic                s1_sign;
    logic [FP_W-1:0]     s1_mag;

    logic                s2_valid;
    logic                s2_sign;
    logic [FP_W-1:0]     s2_mag;
    logic [FP_POS_W-1:0] s2_pos;
    logic                s2_zero;

    logic [FP_W-1:0]     mag_c;
    logic [FP_POS_W-1:0] lod_pos;
    logic                lod_zero;
    logic [FP_W-1:0]     norm_c;
    logic [FP_EXP_W-1:0] exp_c;
    logic [FP_MANT_W-1:0] frac_c;
    logic [FP_W-1:0]     res_c;

    // Whole pipe moves in lockstep whenever the output slot is free or being drained.
    assign advance    = !out_valid_o || out_ready_i;
    assign in_ready_o = advance;

    // Magnitude of the two's-complement input; 0x8000 maps onto itself as unsigned 32768.
    assign mag_c = int_i[FP_SIGN_POS] ? (~int_i + 16'd1) : int_i;

    fp_lod16 u_lod (
        .vec  (s1_mag),
        .pos  (lod_pos),
        .zero (lod_zero)
    );

    // Normalise, truncate to the fraction width and pack; exponent range never leaves 48..78.
    always_comb begin
        norm_c = s2_mag << (4'd15 - s2_pos);
        frac_c = FP_MANT_W'(norm_c >> DROP_W);
        exp_c  = FP_EXP_W'(32'(s2_pos) + 32'(FP_EXP_BIAS) - 32'(FRAC_BITS));
        res_c  = s2_zero ? FP_ZERO : {s2_sign, exp_c, frac_c};
    end

    // Stage 1: capture sign and magnitude.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
        end else if (advance) begin
            s1_valid <= in_valid_i;
            s1_sign  <= int_i[FP_SIGN_POS];
            s1_mag   <= mag_c;
        end
    end

    // Stage 2: capture leading-one position alongside the magnitude.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_mag   <= '0;
            s2_pos   <= '0;
            s2_zero  <= 1'b1;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_mag   <= s1_mag;
            s2_pos   <= lod_pos;
            s2_zero  <= lod_zero;
        end
    end

    // Stage 3: output register, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_o <= 1'b0;
            res_o       <= FP_ZERO;
        end else if (advance) begin
            out_valid_o <= s2_valid;
            res_o       <= res_c;
        end
    end

endmodule
